clk_mode_sched: RTL and testbench
=================================

// Module: clk_mode_sched
// PURPOSE
// Mode scheduler for the digital clock: owns keyboard_ctrl and decides what it edits.
// On a MODE key it loads the running time (or the alarm) into the editor and pauses the timekeeper as needed.
// Validated results are written back to the time counter or the alarm register.
// Sits between key debounce, keyboard_ctrl, time counter, alarm register and display mux.
// PARAMETERS
// TIMEOUT_CYC  500_000_000  idle cycles in an edit state before abandoning the edit (10 s @ 50 MHz)
// CNT_W        29           width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
// clk            in   1   system clock
// rst            in   1   synchronous reset, active-high
// key_mode       in   1   debounced MODE key, 1-cycle pulse
// key_act        in   1   1-cycle pulse on any editor key (p/n/e); restarts timeout
// time_bcd       in   16  running time, BCD {H1,H0,M1,M0}
// alarm_bcd      in   16  stored alarm, BCD {H1,H0,M1,M0}
// kb_data_out    in   16  editor result
// kb_data_out_vld in  1   editor result strobe, 1 cycle
// kb_en          out  1   editor enable
// kb_load        out  1   editor preload strobe
// kb_data_in     out  16  editor preload value
// cnt_pause      out  1   hold timekeeper
// time_load      out  1   write time_data into timekeeper, 1 cycle
// alarm_wr       out  1   write alarm_data into alarm register, 1 cycle
// wr_data        out  16  data for time_load / alarm_wr
// err            out  1   1-cycle pulse: editor result rejected
// mode           out  2   0 RUN, 1 SET_TIME, 2 SET_ALARM (display select)
// BEHAVIOUR
// - Reset: state RUN; all outputs 0; timeout counter 0. Reset mid-edit discards edit, no write.
// - States: RUN, LOAD_T, EDIT_T, WRITE_T, LOAD_A, EDIT_A, WRITE_A.
// - RUN: key_mode -> LOAD_T.
// - LOAD_T (1 cycle): kb_load=1, kb_data_in=time_bcd sampled that cycle, cnt_pause=1 -> EDIT_T.
// - EDIT_T: kb_en=1, cnt_pause=1. vld & valid -> WRITE_T; vld & invalid -> err=1, LOAD_T;
//   key_mode -> LOAD_A; timeout -> RUN.
// - WRITE_T (1 cycle): time_load=1, wr_data=captured result, cnt_pause=1 -> RUN.
// - LOAD_A/EDIT_A/WRITE_A: same, using alarm_bcd and alarm_wr; cnt_pause=0 (time keeps running).
//   In EDIT_A key_mode -> RUN (edit discarded).
// - Latency: key_mode to kb_load = 1 cycle; vld to time_load/alarm_wr = 1 cycle.
// - Valid result: every nibble <= 9, hours {H1,H0} <= 0x23, minutes {M1,M0} <= 0x59.
// - kb_data_out captured on the vld cycle; wr_data holds it until the next capture.
// - Timeout counter: clears on state entry and on key_act; increments in EDIT_*;
//   reaching TIMEOUT_CYC-1 -> RUN, no write, no err.
// - Simultaneous events, priority: vld > key_mode > timeout. key_act with timeout: key_act wins.
// - key_mode in LOAD_*/WRITE_* ignored. vld outside EDIT_* ignored.
// - mode = 1 in *_T states, 2 in *_A states, else 0.
// CONFIGURATION
// CLK_SCHED_ALARM_EN defined: alarm states present as above.
// Not defined: no *_A states; key_mode in EDIT_T -> RUN (edit discarded);
//   alarm_wr tied 0; alarm_bcd unused; mode never 2.
// TESTING (TIMEOUT_CYC=100, CNT_W=7 in the bench)
// 1 time=0x1223, key_mode -> next cycle kb_load=1, kb_data_in=0x1223, mode=1, cnt_pause=1.
// 2 in EDIT_T vld with 0x1530 -> next cycle time_load=1, wr_data=0x1530, then RUN, cnt_pause=0.
// 3 in EDIT_T vld with 0x2460, then 0x1275 -> err pulse each, kb_load reissued, no time_load.
// 4 key_mode twice, alarm=0x0645, vld 0x0700 -> alarm_wr=1, wr_data=0x0700, cnt_pause 0 throughout;
//   without CLK_SCHED_ALARM_EN the 2nd key_mode returns to RUN with no write.
// 5 EDIT_T idle 100 cycles -> RUN, no write; key_act at cycle 90 extends to cycle 190.
// 6 vld and key_mode same cycle in EDIT_T -> WRITE_T; rst during EDIT_T -> RUN, all outputs 0.

Source files
------------

// File: rtl/clk_mode_sched_if.sv
// Signal bundle between the clock mode scheduler and its neighbours (keys, editor,
// timekeeper, alarm register, display mux). master = scheduler side.
interface clk_mode_sched_if;
  logic        key_mode;
  logic        key_act;
  logic [15:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic [15:0] kb_data_out;
  logic        kb_data_out_vld;
  logic        kb_en;
  logic        kb_load;
  logic [15:0] kb_data_in;
  logic        cnt_pause;
  logic        time_load;
  logic        alarm_wr;
  logic [15:0] wr_data;
  logic        err;
  logic [1:0]  mode;

  modport master (
    input  key_mode, key_act, time_bcd, alarm_bcd, kb_data_out, kb_data_out_vld,
    output kb_en, kb_load, kb_data_in, cnt_pause, time_load, alarm_wr, wr_data, err, mode
  );

  modport slave (
    output key_mode, key_act, time_bcd, alarm_bcd, kb_data_out, kb_data_out_vld,
    input  kb_en, kb_load, kb_data_in, cnt_pause, time_load, alarm_wr, wr_data, err, mode
  );
endinterface

// File: rtl/clk_mode_sched.sv
// Digital clock mode scheduler: drives keyboard_ctrl to edit time (and alarm when
// CLK_SCHED_ALARM_EN is defined), validates results and writes them back.
module clk_mode_sched #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned CNT_W       = 29
) (
  input logic              clk,
  input logic              rst,
  clk_mode_sched_if.master bus
);

`ifdef CLK_SCHED_ALARM_EN
  typedef enum logic [2:0] {
    StRun, StLoadT, StEditT, StWriteT, StLoadA, StEditA, StWriteA
  } state_e;
  localparam state_e ModeFromEditT = StLoadA;
`else
  typedef enum logic [2:0] {
    StRun, StLoadT, StEditT, StWriteT
  } state_e;
  localparam state_e ModeFromEditT = StRun;
  logic unused_alarm;
  assign unused_alarm = ^bus.alarm_bcd;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic   is_edit;
  state_e wr_st, ld_st, md_st;
  logic   result_ok;
  logic   timeout;

  function automatic logic bcd_time_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) && (v[15:8] <= 8'h23) && (v[7:0] <= 8'h59);
  endfunction

  assign result_ok = bcd_time_ok(bus.kb_data_out);
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Both edit states share one step; only their successor states differ.
  always_comb begin
    is_edit = (state_q == StEditT);
    wr_st   = StWriteT;
    ld_st   = StLoadT;
    md_st   = ModeFromEditT;
`ifdef CLK_SCHED_ALARM_EN
    if (state_q == StEditA) begin
      is_edit = 1'b1;
      wr_st   = StWriteA;
      ld_st   = StLoadA;
      md_st   = StRun;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    err_d     = 1'b0;
    wr_data_d = wr_data_q;
    if (is_edit) begin
      if (bus.kb_data_out_vld) begin
        wr_data_d = bus.kb_data_out;
        if (result_ok) begin
          state_d = wr_st;
        end else begin
          state_d = ld_st;
          err_d   = 1'b1;
        end
      end else if (bus.key_mode) begin
        state_d = md_st;
      end else if (bus.key_act) begin
        cnt_d = '0;
      end else if (timeout) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        StRun:    if (bus.key_mode) state_d = StLoadT;
        StLoadT:  state_d = StEditT;
        StWriteT: state_d = StRun;
`ifdef CLK_SCHED_ALARM_EN
        StLoadA:  state_d = StEditA;
        StWriteA: state_d = StRun;
`endif
        default:  state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    bus.kb_en      = is_edit;
    bus.kb_load    = 1'b0;
    bus.kb_data_in = '0;
    bus.cnt_pause  = 1'b0;
    bus.time_load  = 1'b0;
    bus.alarm_wr   = 1'b0;
    bus.mode       = 2'd0;
    unique case (state_q)
      StLoadT: begin
        bus.kb_load    = 1'b1;
        bus.kb_data_in = bus.time_bcd;
        bus.cnt_pause  = 1'b1;
        bus.mode       = 2'd1;
      end
      StEditT: begin
        bus.cnt_pause = 1'b1;
        bus.mode      = 2'd1;
      end
      StWriteT: begin
        bus.time_load = 1'b1;
        bus.cnt_pause = 1'b1;
        bus.mode      = 2'd1;
      end
`ifdef CLK_SCHED_ALARM_EN
      StLoadA: begin
        bus.kb_load    = 1'b1;
        bus.kb_data_in = bus.alarm_bcd;
        bus.mode       = 2'd2;
      end
      StEditA:  bus.mode = 2'd2;
      StWriteA: begin
        bus.alarm_wr = 1'b1;
        bus.mode     = 2'd2;
      end
`endif
      default: ;
    endcase
  end

  assign bus.wr_data = wr_data_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_clk_mode_sched.sv
// Directed bench for clk_mode_sched with a short timeout; alarm checks follow
// whether CLK_SCHED_ALARM_EN is defined.
module tb_clk_mode_sched;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  clk_mode_sched_if bus ();

  clk_mode_sched #(
    .TIMEOUT_CYC(100),
    .CNT_W      (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    bus.key_mode = 1'b1;
    tick();
    bus.key_mode = 1'b0;
  endtask

  task automatic pulse_vld(input logic [15:0] d);
    bus.kb_data_out     = d;
    bus.kb_data_out_vld = 1'b1;
    tick();
    bus.kb_data_out_vld = 1'b0;
  endtask

  task automatic enter_edit_t();
    pulse_mode();
    tick();
  endtask

  function automatic logic [39:0] all_outs();
    return {bus.kb_en, bus.kb_load, bus.kb_data_in, bus.cnt_pause, bus.time_load,
            bus.alarm_wr, bus.wr_data, bus.err, bus.mode};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (all_outs() !== 40'd0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (all_outs() !== 40'd0) begin
      n_bad++; $display("FAIL idle_outs: got %h want 0", all_outs());
    end
  endtask

  task automatic test_load();
    bus.time_bcd = 16'h1223;
    pulse_mode();
    n_cmp++;
    if ({bus.kb_load, bus.kb_data_in, bus.mode, bus.cnt_pause, bus.kb_en} !== {1'b1, 16'h1223, 2'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL load_t: got %b %h %0d %b %b want 1 1223 1 1 0",
                        bus.kb_load, bus.kb_data_in, bus.mode, bus.cnt_pause, bus.kb_en);
    end
    tick();
    n_cmp++;
    if ({bus.kb_en, bus.kb_load, bus.cnt_pause, bus.mode} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
      n_bad++; $display("FAIL edit_t: got en=%b ld=%b p=%b m=%0d want 1 0 1 1",
                        bus.kb_en, bus.kb_load, bus.cnt_pause, bus.mode);
    end
  endtask

  task automatic test_write();
    pulse_vld(16'h1530);
    n_cmp++;
    if ({bus.time_load, bus.wr_data, bus.cnt_pause, bus.err, bus.alarm_wr} !== {1'b1, 16'h1530, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL write_t: got tl=%b wd=%h p=%b err=%b aw=%b want 1 1530 1 0 0",
                        bus.time_load, bus.wr_data, bus.cnt_pause, bus.err, bus.alarm_wr);
    end
    tick();
    n_cmp++;
    if ({bus.time_load, bus.cnt_pause, bus.mode, bus.wr_data} !== {1'b0, 1'b0, 2'd0, 16'h1530}) begin
      n_bad++; $display("FAIL after_write: got tl=%b p=%b m=%0d wd=%h want 0 0 0 1530",
                        bus.time_load, bus.cnt_pause, bus.mode, bus.wr_data);
    end
  endtask

  task automatic test_reject();
    enter_edit_t();
    pulse_vld(16'h2460);
    n_cmp++;
    if ({bus.err, bus.kb_load, bus.time_load, bus.mode} !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL reject_hours: got err=%b ld=%b tl=%b m=%0d want 1 1 0 1",
                        bus.err, bus.kb_load, bus.time_load, bus.mode);
    end
    tick();
    n_cmp++;
    if ({bus.err, bus.kb_en} !== 2'b01) begin
      n_bad++; $display("FAIL err_one_cycle: got err=%b en=%b want 0 1", bus.err, bus.kb_en);
    end
    pulse_vld(16'h1275);
    n_cmp++;
    if ({bus.err, bus.kb_load, bus.time_load} !== 3'b110) begin
      n_bad++; $display("FAIL reject_mins: got err=%b ld=%b tl=%b want 1 1 0",
                        bus.err, bus.kb_load, bus.time_load);
    end
    tick();
    pulse_vld(16'h2359);
    n_cmp++;
    if ({bus.time_load, bus.err, bus.wr_data} !== {1'b1, 1'b0, 16'h2359}) begin
      n_bad++; $display("FAIL accept_2359: got tl=%b err=%b wd=%h want 1 0 2359",
                        bus.time_load, bus.err, bus.wr_data);
    end
    tick();
  endtask

  task automatic test_alarm();
    bus.alarm_bcd = 16'h0645;
    enter_edit_t();
    pulse_mode();
`ifdef CLK_SCHED_ALARM_EN
    n_cmp++;
    if ({bus.kb_load, bus.kb_data_in, bus.mode, bus.cnt_pause} !== {1'b1, 16'h0645, 2'd2, 1'b0}) begin
      n_bad++; $display("FAIL load_a: got %b %h %0d %b want 1 0645 2 0",
                        bus.kb_load, bus.kb_data_in, bus.mode, bus.cnt_pause);
    end
    tick();
    n_cmp++;
    if ({bus.kb_en, bus.mode, bus.cnt_pause} !== {1'b1, 2'd2, 1'b0}) begin
      n_bad++; $display("FAIL edit_a: got en=%b m=%0d p=%b want 1 2 0",
                        bus.kb_en, bus.mode, bus.cnt_pause);
    end
    pulse_vld(16'h0700);
    n_cmp++;
    if ({bus.alarm_wr, bus.time_load, bus.wr_data, bus.cnt_pause} !== {1'b1, 1'b0, 16'h0700, 1'b0}) begin
      n_bad++; $display("FAIL write_a: got aw=%b tl=%b wd=%h p=%b want 1 0 0700 0",
                        bus.alarm_wr, bus.time_load, bus.wr_data, bus.cnt_pause);
    end
    tick();
    enter_edit_t();
    pulse_mode();
    tick();
    pulse_mode();
    n_cmp++;
    if ({bus.mode, bus.alarm_wr, bus.kb_en} !== {2'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL abandon_a: got m=%0d aw=%b en=%b want 0 0 0",
                        bus.mode, bus.alarm_wr, bus.kb_en);
    end
`else
    n_cmp++;
    if ({bus.mode, bus.kb_en, bus.kb_load, bus.alarm_wr, bus.time_load} !== {2'd0, 4'b0000}) begin
      n_bad++; $display("FAIL mode_to_run: got m=%0d en=%b ld=%b aw=%b tl=%b want 0 0 0 0 0",
                        bus.mode, bus.kb_en, bus.kb_load, bus.alarm_wr, bus.time_load);
    end
    tick();
    n_cmp++;
    if ({bus.mode, bus.alarm_wr, bus.time_load} !== {2'd0, 2'b00}) begin
      n_bad++; $display("FAIL no_write: got m=%0d aw=%b tl=%b want 0 0 0",
                        bus.mode, bus.alarm_wr, bus.time_load);
    end
`endif
  endtask

  task automatic test_timeout();
    logic wrote;
    wrote = 1'b0;
    enter_edit_t();
    for (int i = 0; i < 99; i++) begin
      tick();
      wrote |= bus.time_load | bus.err | bus.alarm_wr;
    end
    n_cmp++;
    if (bus.mode !== 2'd1) begin
      n_bad++; $display("FAIL edit_cycle99: got m=%0d want 1", bus.mode);
    end
    tick();
    wrote |= bus.time_load | bus.err | bus.alarm_wr;
    n_cmp++;
    if ({bus.mode, bus.kb_en, wrote} !== {2'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL timeout: got m=%0d en=%b wrote=%b want 0 0 0",
                        bus.mode, bus.kb_en, wrote);
    end
    enter_edit_t();
    repeat (90) tick();
    bus.key_act = 1'b1;
    tick();
    bus.key_act = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if (bus.mode !== 2'd1) begin
      n_bad++; $display("FAIL extended_c100: got m=%0d want 1", bus.mode);
    end
    repeat (90) tick();
    n_cmp++;
    if ({bus.mode, bus.kb_en} !== {2'd1, 1'b1}) begin
      n_bad++; $display("FAIL extended_c190: got m=%0d en=%b want 1 1", bus.mode, bus.kb_en);
    end
    tick();
    n_cmp++;
    if ({bus.mode, bus.time_load, bus.err} !== {2'd0, 2'b00}) begin
      n_bad++; $display("FAIL extended_c191: got m=%0d tl=%b err=%b want 0 0 0",
                        bus.mode, bus.time_load, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    enter_edit_t();
    bus.kb_data_out     = 16'h0815;
    bus.kb_data_out_vld = 1'b1;
    bus.key_mode        = 1'b1;
    tick();
    bus.kb_data_out_vld = 1'b0;
    bus.key_mode        = 1'b0;
    n_cmp++;
    if ({bus.time_load, bus.wr_data, bus.mode, bus.kb_load} !== {1'b1, 16'h0815, 2'd1, 1'b0}) begin
      n_bad++; $display("FAIL vld_beats_mode: got tl=%b wd=%h m=%0d ld=%b want 1 0815 1 0",
                        bus.time_load, bus.wr_data, bus.mode, bus.kb_load);
    end
    tick();
    pulse_vld(16'h1234);
    n_cmp++;
    if ({bus.time_load, bus.wr_data, bus.mode} !== {1'b0, 16'h0815, 2'd0}) begin
      n_bad++; $display("FAIL vld_in_run: got tl=%b wd=%h m=%0d want 0 0815 0",
                        bus.time_load, bus.wr_data, bus.mode);
    end
    bus.key_mode = 1'b1;
    tick();
    tick();
    bus.key_mode = 1'b0;
    n_cmp++;
    if ({bus.mode, bus.kb_en, bus.kb_load} !== {2'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL mode_in_load: got m=%0d en=%b ld=%b want 1 1 0",
                        bus.mode, bus.kb_en, bus.kb_load);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (all_outs() !== 40'd0) begin
      n_bad++; $display("FAIL rst_mid_edit: got %h want 0", all_outs());
    end
    tick();
    n_cmp++;
    if (all_outs() !== 40'd0) begin
      n_bad++; $display("FAIL after_rst: got %h want 0", all_outs());
    end
  endtask

  initial begin
    n_cmp               = 0;
    n_bad               = 0;
    rst                 = 1'b1;
    bus.key_mode        = 1'b0;
    bus.key_act         = 1'b0;
    bus.time_bcd        = 16'h0000;
    bus.alarm_bcd       = 16'h0000;
    bus.kb_data_out     = 16'h0000;
    bus.kb_data_out_vld = 1'b0;
    test_reset();
    test_load();
    test_write();
    test_reject();
    test_alarm();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
